// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: WIDTH-bit Fibonacci LFSR stepped once every DIVIDE falling
// edges of clk_60, with runtime seeding and an all-zero lockup escape.
// Optional macro RAND_BOUND_EN adds a modulo-reduction engine that delivers
// the stepped value reduced into [0, bound) with a completion strobe.
// Without RAND_BOUND_EN the bounded outputs mirror the raw LFSR outputs.
module lfsr_rand_gen #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = 8'h1D,
   parameter int               DIVIDE     = 21,
   parameter logic [WIDTH-1:0] SEED_RESET = 8'h01
) (
   input  logic             clk_60,
   input  logic             reset,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] bound,
   output logic [WIDTH-1:0] random_data,
   output logic             rnd_valid,
   output logic [WIDTH-1:0] rnd_bounded,
   output logic             bounded_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int               CNT_W    = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_state;
   logic             r_rnd_valid;

   logic             w_fb;
   logic [WIDTH-1:0] w_next;
   logic             w_step;

   // An all-zero state would never leave zero, so feedback is forced to 1 there.
   assign w_fb   = (r_state == '0) ? 1'b1 : ^(r_state & TAPS);
   assign w_next = {w_fb, r_state[WIDTH-1:1]};
   // A seed load on a terminal count suppresses the step.
   assign w_step = enable & ~seed_load & (r_cnt == CNT_LAST);

   // Prescaler and LFSR state; seed_load overrides a pending step.
   always_ff @(negedge clk_60 or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_state     <= SEED_RESET;
         r_rnd_valid <= 1'b0;
      end else begin
         r_rnd_valid <= 1'b0;
         if (seed_load) begin
            r_state <= seed;
            r_cnt   <= '0;
         end else if (enable) begin
            if (r_cnt == CNT_LAST) begin
               r_cnt       <= '0;
               r_state     <= w_next;
               r_rnd_valid <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign random_data = r_state;
   assign rnd_valid   = r_rnd_valid;

`ifdef RAND_BOUND_EN
   typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DONE} state_t;

   state_t           r_fsm;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_bounded;
   logic             r_bvalid;
   logic             r_busy;
   logic             r_overrun;

   // Reduction by repeated subtraction; a step arriving while busy is dropped
   // and flagged in the sticky overrun bit.
   always_ff @(negedge clk_60 or posedge reset) begin
      if (reset) begin
         r_fsm     <= S_IDLE;
         r_rem     <= '0;
         r_bounded <= '0;
         r_bvalid  <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_bvalid <= 1'b0;
         if (seed_load) begin
            r_fsm     <= S_IDLE;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
         end else begin
            case (r_fsm)
               S_IDLE: begin
                  if (w_step) begin
                     r_rem  <= w_next;
                     r_fsm  <= S_REDUCE;
                     r_busy <= 1'b1;
                  end
               end
               S_REDUCE: begin
                  if (w_step) r_overrun <= 1'b1;
                  if ((bound == '0) || (r_rem < bound)) r_fsm <= S_DONE;
                  else r_rem <= r_rem - bound;
               end
               S_DONE: begin
                  if (w_step) r_overrun <= 1'b1;
                  r_bounded <= r_rem;
                  r_bvalid  <= 1'b1;
                  r_busy    <= 1'b0;
                  r_fsm     <= S_IDLE;
               end
               default: begin
                  r_fsm  <= S_IDLE;
                  r_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rnd_bounded   = r_bounded;
   assign bounded_valid = r_bvalid;
   assign busy          = r_busy;
   assign overrun       = r_overrun;
`else
   logic w_unused_bound;

   assign w_unused_bound = ^bound;
   assign rnd_bounded    = r_state;
   assign bounded_valid  = r_rnd_valid;
   assign busy           = 1'b0;
   assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen (WIDTH 8, TAPS 8'h1D, DIVIDE 21, seed 8'h01).
// Checks the reduction engine when RAND_BOUND_EN is defined, mirroring otherwise.
module tb_lfsr_rand_gen;
   logic       clk_60 = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       seed_load = 1'b0;
   logic [7:0] seed = 8'h00;
   logic [7:0] bound = 8'h00;
   logic [7:0] random_data;
   logic [7:0] rnd_bounded;
   logic       rnd_valid;
   logic       bounded_valid;
   logic       busy;
   logic       overrun;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_60 = ~clk_60;

   lfsr_rand_gen #(
      .WIDTH(8), .TAPS(8'h1D), .DIVIDE(21), .SEED_RESET(8'h01)
   ) dut (
      .clk_60(clk_60), .reset(reset), .enable(enable), .seed_load(seed_load),
      .seed(seed), .bound(bound), .random_data(random_data), .rnd_valid(rnd_valid),
      .rnd_bounded(rnd_bounded), .bounded_valid(bounded_valid), .busy(busy),
      .overrun(overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance past one active (falling) edge and settle.
   task automatic step_edge();
      @(negedge clk_60);
      #1;
   endtask

   // Edges until rnd_valid is seen (0 on timeout).
   task automatic run_until_valid(input int max_edges, output int n);
      n = 0;
      for (int i = 1; i <= max_edges; i++) begin
         step_edge();
         if (rnd_valid) begin
            n = i;
            break;
         end
      end
   endtask

   // Edges until bounded_valid (0 on timeout); nb counts busy samples before it.
   task automatic run_until_bvalid(input int max_edges, output int n, output int nb);
      n  = 0;
      nb = busy ? 1 : 0;
      for (int i = 1; i <= max_edges; i++) begin
         step_edge();
         if (bounded_valid) begin
            n = i;
            break;
         end
         if (busy) nb++;
      end
   endtask

   initial begin
      int n, nb, pulses;

      // Reset state
      step_edge();
      step_edge();
      check("rst_data", random_data, 8'h01);
      check("rst_valid", rnd_valid, 1'b0);
      check("rst_bvalid", bounded_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
`ifdef RAND_BOUND_EN
      check("rst_bounded", rnd_bounded, 8'h00);
`else
      check("rst_bounded", rnd_bounded, 8'h01);
`endif

      // Free-running sequence 80, 40, 20, 10, 88 every 21 edges
      reset  = 1'b0;
      enable = 1'b1;
      run_until_valid(60, n);
      check("period_80", n, 21);
      check("data_80", random_data, 8'h80);
      step_edge();
      check("valid_pulse_1cyc", rnd_valid, 1'b0);
      run_until_valid(60, n);
      check("period_40", n, 20);
      check("data_40", random_data, 8'h40);
      run_until_valid(60, n);
      check("period_20", n, 21);
      check("data_20", random_data, 8'h20);
      run_until_valid(60, n);
      check("period_10", n, 21);
      check("data_10", random_data, 8'h10);
      step_edge();
      step_edge();
      step_edge();
      bound = 8'd10;
      run_until_valid(60, n);
      check("period_88", n, 18);
      check("data_88", random_data, 8'h88);

      // 136 mod 10 = 6 after 13 subtractions
`ifdef RAND_BOUND_EN
      check("busy_at_step", busy, 1'b1);
      run_until_bvalid(60, n, nb);
      check("bvalid_latency", n, 15);
      check("busy_edges", nb, 15);
      check("bounded_88", rnd_bounded, 8'h06);
      check("busy_done", busy, 1'b0);
      bound = 8'd0;
      run_until_valid(60, n);
      check("period_c4", n, 6);
`else
      check("bvalid_mirror", bounded_valid, 1'b1);
      check("bounded_mirror", rnd_bounded, 8'h88);
      check("busy_off", busy, 1'b0);
      bound = 8'd0;
      run_until_valid(60, n);
      check("period_c4", n, 21);
`endif
      check("data_c4", random_data, 8'hC4);

      // Overrun: bound=1 on 0x88 keeps the engine busy past the next step
      step_edge();
      step_edge();
      step_edge();
      seed_load = 1'b1;
      seed      = 8'h10;
      step_edge();
      seed_load = 1'b0;
      check("seed_data", random_data, 8'h10);
      check("seed_no_valid", rnd_valid, 1'b0);
      bound = 8'd1;
      run_until_valid(60, n);
      check("period_seed", n, 21);
      check("seed_step_88", random_data, 8'h88);
      run_until_valid(60, n);
      check("period_ovr", n, 21);
      check("ovr_data_c4", random_data, 8'hC4);
`ifdef RAND_BOUND_EN
      check("overrun_set", overrun, 1'b1);
      run_until_bvalid(300, n, nb);
      check("ovr_bvalid_lat", n, 117);
      check("ovr_bounded", rnd_bounded, 8'h00);
      check("ovr_sticky", overrun, 1'b1);
`else
      check("overrun_off", overrun, 1'b0);
`endif

      // seed_load clears the engine; seed 0x55 then seed 0 on a terminal count
      bound     = 8'd0;
      seed_load = 1'b1;
      seed      = 8'h55;
      step_edge();
      seed_load = 1'b0;
      check("seed55_data", random_data, 8'h55);
      check("seed_clr_overrun", overrun, 1'b0);
      check("seed_clr_busy", busy, 1'b0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step_edge();
         if (rnd_valid) pulses++;
      end
      check("pre_tc_pulses", pulses, 0);
      seed_load = 1'b1;
      seed      = 8'h00;
      step_edge();
      seed_load = 1'b0;
      check("tc_seed_no_valid", rnd_valid, 1'b0);
      check("tc_seed_data", random_data, 8'h00);
      run_until_valid(60, n);
      check("tc_period", n, 21);
      check("zero_escape", random_data, 8'h80);

      // enable low for 50 edges after 5 counts
      for (int i = 0; i < 5; i++) step_edge();
      enable = 1'b0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         step_edge();
         if (rnd_valid) pulses++;
      end
      check("frozen_pulses", pulses, 0);
      check("frozen_data", random_data, 8'h80);
      enable = 1'b1;
      run_until_valid(60, n);
      check("resume_period", n, 16);
      check("resume_data", random_data, 8'h40);

      // Asynchronous reset while the engine is busy
      step_edge();
      step_edge();
      step_edge();
      bound = 8'd1;
      run_until_valid(60, n);
      check("pre_rst_period", n, 18);
      check("pre_rst_data", random_data, 8'h20);
      step_edge();
      step_edge();
      step_edge();
`ifdef RAND_BOUND_EN
      check("pre_rst_busy", busy, 1'b1);
`endif
      #2;
      reset = 1'b1;
      #1;
      check("arst_data", random_data, 8'h01);
      check("arst_busy", busy, 1'b0);
      check("arst_overrun", overrun, 1'b0);
      check("arst_valid", rnd_valid, 1'b0);
`ifdef RAND_BOUND_EN
      check("arst_bounded", rnd_bounded, 8'h00);
`else
      check("arst_bounded", rnd_bounded, 8'h01);
`endif
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step_edge();
         if (bounded_valid) pulses++;
      end
      check("arst_no_bvalid", pulses, 0);
      reset = 1'b0;
      step_edge();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/lfsr_rand_gen.md
# lfsr_rand_gen

Parametrised pseudo-random source for the game logic: a WIDTH-bit Fibonacci LFSR with programmable taps and a programmable update period. It adds runtime seeding, all-zero lockup escape, and an optional modulo-reduction engine that delivers a value in [0, bound) with a completion strobe. It sits between the clk_60 domain timing logic and any consumer needing random positions or delays.

## Interface
- WIDTH, 8: LFSR and data width (≥ 3).
- TAPS, 8'h1D: feedback mask; bit i set means state[i] feeds the XOR.
- DIVIDE, 21: clk_60 edges per LFSR step (≥ 2).
- SEED_RESET, 8'h01: state loaded by reset (WIDTH bits).
- clk_60  in  1  system clock; all state updates on its falling edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  prescaler runs while high; holds (count frozen) while low.
- seed_load  in  1  synchronous load of seed.
- seed  in  WIDTH  value loaded by seed_load.
- bound  in  WIDTH  modulus for the bounded output; 0 means no reduction.
- random_data  out  WIDTH  current LFSR state.
- rnd_valid  out  1  one-cycle pulse on the edge the state steps.
- rnd_bounded  out  WIDTH  last reduced value.
- bounded_valid  out  1  one-cycle pulse when rnd_bounded updates.
- busy  out  1  reduction engine active.
- overrun  out  1  sticky: a step occurred while busy.

## Operation
- Prescaler cnt counts 0..DIVIDE-1 while enable; at DIVIDE-1 it wraps to 0 and the LFSR steps.
- Step: fb = XOR of state[i] over TAPS[i]=1; state <= {fb, state[WIDTH-1:1]}.
- Lockup escape: if state == 0, fb is forced to 1 (0 steps to 1<<(WIDTH-1)).
- seed_load has priority over a step: state <= seed, cnt <= 0, engine to IDLE, busy 0, overrun 0, no rnd_valid. Seed 0 is accepted; the escape handles it.
- Reduction FSM, states IDLE/REDUCE/DONE:
  - IDLE, step: r <= new state value (the one being loaded); go REDUCE, busy 1.
  - REDUCE: if bound == 0 or r < bound, go DONE; else r <= r - bound.
  - DONE: rnd_bounded <= r, bounded_valid 1, busy 0, go IDLE.
  - bound is sampled every REDUCE cycle and must be held stable while busy.
  - A step while busy (REDUCE or DONE) still updates the LFSR and pulses rnd_valid. The engine ignores the sample and sets overrun.
- Reset values: random_data = SEED_RESET, cnt 0, FSM IDLE, rnd_bounded 0, rnd_valid 0, bounded_valid 0, busy 0, overrun 0.

## Timing
- rnd_valid rises on the step edge; random_data holds the new value from that edge.
- Period between steps is exactly DIVIDE edges with enable held high.
- Reduction latency: with k = floor(v/bound), REDUCE runs k+1 cycles, so bounded_valid asserts k+2 edges after the step edge. With bound=0 it asserts 2 edges after.
- Reset mid-reduction aborts immediately; no bounded_valid is produced.
- enable low freezes cnt only. An in-flight reduction still completes.

## Configuration
- RAND_BOUND_EN defined: reduction engine present as above.
- RAND_BOUND_EN undefined: no FSM. rnd_bounded = random_data, bounded_valid = rnd_valid, busy = 0, overrun = 0. The bound port is ignored.

## Test plan
- Reset with defaults, enable=1 -> random_data 8'h01. rnd_valid pulses every 21 edges; the sequence is 8'h80, 8'h40, 8'h20, 8'h10, 8'h88.
- seed_load seed=8'h00 then run -> first step gives 8'h80, never stuck at 0. seed_load in the same cycle as a terminal count -> state=seed, no rnd_valid, next step 21 edges later.
- Step to 8'h88 with bound=10 -> bounded_valid 15 edges after the step edge, rnd_bounded 6. busy is high for those 15 edges.
- bound=1, step to 8'h88 (136 subtractions) -> the next step 21 edges later sets overrun. Its sample is dropped; the final rnd_bounded is 0; seed_load clears overrun.
- enable low for 50 edges mid-count -> no rnd_valid and cnt frozen; resumes with the remaining count.
- Assert reset while busy -> all outputs return to reset values asynchronously; no bounded_valid. With RAND_BOUND_EN undefined, bounded_valid mirrors rnd_valid.
